// File: rtl/int_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: radix-2 shift-add multiplier and
// restoring divider on operand magnitudes, with sign fix-up and a zero/overflow fast path.
module int_muldiv_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned ROB_ID_WIDTH = 4,
  parameter bit          EARLY_OUT    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_aH,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [2:0]              funct3,
  input  logic [XLEN-1:0]         src1,
  input  logic [XLEN-1:0]         src2,
  input  logic [ROB_ID_WIDTH-1:0] instr_rob_id_in,
  input  logic                    flush,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [ROB_ID_WIDTH-1:0] instr_rob_id_out,
  output logic [XLEN-1:0]         dst
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e                  state_q, state_d;
  logic [2:0]              op_q, op_d;
  logic [ROB_ID_WIDTH-1:0] rob_q, rob_d;
  logic                    neg1_q, neg1_d, neg2_q, neg2_d;
  logic [XLEN-1:0]         op2_q, op2_d;
  logic [2*XLEN-1:0]       acc_q, acc_d;
  logic [XLEN-1:0]         rem_q, rem_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [XLEN-1:0]         res_q, res_d;

  logic            s1_signed, s2_signed, src1_neg, src2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_zero, div_ovf, mul_zero, fast;
  logic [XLEN-1:0] fast_res;
  logic [XLEN:0]   mul_sum, div_part;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] quot, remv, fix_res;

  assign s1_signed = funct3[2] ? ~funct3[0] : ~(funct3[1] & funct3[0]);
  assign s2_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign src1_neg  = s1_signed & src1[XLEN-1];
  assign src2_neg  = s2_signed & src2[XLEN-1];
  assign mag1      = src1_neg ? -src1 : src1;
  assign mag2      = src2_neg ? -src2 : src2;

  assign div_zero = funct3[2] && (src2 == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (src2 == {XLEN{1'b1}});
  assign mul_zero = EARLY_OUT && !funct3[2] && ((src1 == '0) || (src2 == '0));
  assign fast     = div_zero | div_ovf | mul_zero;

  always_comb begin
    fast_res = '0;
    if (div_zero) begin
      fast_res = funct3[1] ? src1 : {XLEN{1'b1}};
    end else if (div_ovf) begin
      fast_res = funct3[1] ? '0 : src1;
    end
  end

  // Multiplier sits in the low half of acc and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, op2_q} : {(XLEN+1){1'b0}});
  // Dividend bits shift out of the low half of acc; quotient bits shift in behind them.
  assign div_part = {rem_q, acc_q[XLEN-1]};
  assign div_ge   = div_part >= {1'b0, op2_q};
  assign div_rem  = div_ge ? XLEN'(div_part - {1'b0, op2_q}) : div_part[XLEN-1:0];

  assign prod = (neg1_q ^ neg2_q) ? -acc_q : acc_q;
  assign quot = (neg1_q ^ neg2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign remv = neg1_q ? -rem_q : rem_q;

  always_comb begin
    fix_res = '0;
    unique case (op_q)
      3'b000:                 fix_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quot;
      default:                fix_res = remv;
    endcase
  end

  assign issue_ready      = (state_q == StIdle) & ~flush;
  assign result_valid     = (state_q == StDone) & ~flush;
  assign instr_rob_id_out = rob_q;
  assign dst              = res_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rob_d   = rob_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
    op2_d   = op2_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      StIdle: begin
        if (issue_valid && issue_ready) begin
          op_d   = funct3;
          rob_d  = instr_rob_id_in;
          neg1_d = src1_neg;
          neg2_d = src2_neg;
          op2_d  = mag2;
          acc_d  = {{XLEN{1'b0}}, mag1};
          rem_d  = '0;
          cnt_d  = '0;
          if (fast) begin
            res_d   = fast_res;
            state_d = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (op_q[2]) begin
          rem_d = div_rem;
          acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(XLEN - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        res_d   = fix_res;
        state_d = StDone;
      end
      StDone: begin
        if (result_valid && result_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst_aH) begin
    if (rst_aH) begin
      state_q <= StIdle;
      op_q    <= '0;
      rob_q   <= '0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      op2_q   <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rob_q   <= rob_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      op2_q   <= op2_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_int_muldiv_unit.sv
// Scoreboard bench for int_muldiv_unit: directed ops push expected results, a negedge
// monitor pops and compares data, tag and latency; a second instance covers EARLY_OUT=0.
module tb_int_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_aH = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  funct3 = '0;
  logic [31:0] src1 = '0, src2 = '0;
  logic [3:0]  rob_in = '0;
  logic        flush = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b1;
  logic [3:0]  rob_out;
  logic [31:0] dst;

  logic        e_valid = 1'b0;
  logic        e_ready;
  logic [2:0]  e_funct3 = '0;
  logic [31:0] e_src1 = '0, e_src2 = '0;
  logic [3:0]  e_rob_in = '0;
  logic        e_rvalid;
  logic [3:0]  e_rob_out;
  logic [31:0] e_dst;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  int_muldiv_unit #(.XLEN(32), .ROB_ID_WIDTH(4), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst_aH(rst_aH), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .funct3(funct3), .src1(src1), .src2(src2), .instr_rob_id_in(rob_in), .flush(flush),
    .result_valid(result_valid), .result_ready(result_ready), .instr_rob_id_out(rob_out),
    .dst(dst)
  );

  int_muldiv_unit #(.XLEN(32), .ROB_ID_WIDTH(4), .EARLY_OUT(1'b0)) dut_slow (
    .clk(clk), .rst_aH(rst_aH), .issue_valid(e_valid), .issue_ready(e_ready),
    .funct3(e_funct3), .src1(e_src1), .src2(e_src2), .instr_rob_id_in(e_rob_in),
    .flush(1'b0), .result_valid(e_rvalid), .result_ready(1'b1),
    .instr_rob_id_out(e_rob_out), .dst(e_dst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer an op until accepted; optionally record its expected result and latency.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] id, input bit push, input logic [31:0] exp,
                       input int lat);
    bit   ok;
    exp_t e;
    @(posedge clk); #1;
    issue_valid = 1'b1; funct3 = f; src1 = a; src2 = b; rob_in = id;
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (issue_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok && push) begin
      e.id = id; e.data = exp; e.due = cyc + lat;
      sb.push_back(e);
    end
    if (!ok) chk("issue_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: latency on first valid cycle, data/tag on every valid cycle, pop on handshake.
  initial begin : monitor
    bit in_result;
    in_result = 1'b0;
    forever begin
      @(negedge clk);
      if (result_valid) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_result: got dst %0h rob %0h, required no result", dst, rob_out);
        end else begin
          if (!in_result) chk("latency_due_cycle", 64'(cyc), 64'(sb[0].due));
          chk("dst", {32'd0, dst}, {32'd0, sb[0].data});
          chk("rob_id", {60'd0, rob_out}, {60'd0, sb[0].id});
          chk("issue_ready_while_busy", {63'd0, issue_ready}, 64'd0);
          if (result_ready) begin
            void'(sb.pop_front());
            in_result = 1'b0;
          end else begin
            in_result = 1'b1;
          end
        end
      end
    end
  end

  // EARLY_OUT=0: a zero-operand multiply takes the full iterative path.
  initial begin : slow_path
    int  t0;
    bit  seen;
    @(negedge rst_aH);
    @(posedge clk); #1;
    e_valid = 1'b1; e_funct3 = 3'b000; e_src1 = 32'h0; e_src2 = 32'h123; e_rob_in = 4'd3;
    @(negedge clk);
    t0 = cyc;
    @(posedge clk); #1;
    e_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (e_rvalid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("slow_mul0_seen", {63'd0, seen}, 64'd1);
    chk("slow_mul0_latency", 64'(cyc - t0), 64'd34);
    chk("slow_mul0_dst", {32'd0, e_dst}, 64'd0);
    chk("slow_mul0_rob", {60'd0, e_rob_out}, 64'd3);
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit seen;
    repeat (3) @(posedge clk);
    #1 rst_aH = 1'b0;
    @(negedge clk);
    chk("reset_issue_ready", {63'd0, issue_ready}, 64'd1);
    chk("reset_result_valid", {63'd0, result_valid}, 64'd0);
    chk("reset_dst", {32'd0, dst}, 64'd0);
    chk("reset_rob", {60'd0, rob_out}, 64'd0);

    issue(3'b000, 32'd7,        32'hFFFF_FFFD, 4'd1,  1'b1, 32'hFFFF_FFEB, 34);
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 4'd2, 1'b1, 32'h4000_0000, 34);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 1'b1, 32'hFFFF_FFFE, 34);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 1'b1, 32'hFFFF_FFFF, 34);
    issue(3'b001, 32'hFFFF_FFFF, 32'd5,         4'd5, 1'b1, 32'hFFFF_FFFF, 34);
    issue(3'b100, 32'hFFFF_FFF9, 32'd2,         4'd6, 1'b1, 32'hFFFF_FFFD, 34);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2,         4'd7, 1'b1, 32'hFFFF_FFFF, 34);
    issue(3'b101, 32'd100,       32'd7,         4'd8, 1'b1, 32'd14,        34);
    issue(3'b111, 32'd100,       32'd7,         4'd9, 1'b1, 32'd2,         34);
    issue(3'b101, 32'hFFFF_FFFF, 32'h10,        4'd10, 1'b1, 32'h0FFF_FFFF, 34);
    issue(3'b101, 32'd5,         32'd0,         4'd11, 1'b1, 32'hFFFF_FFFF, 1);
    issue(3'b110, 32'd5,         32'd0,         4'd12, 1'b1, 32'd5,         1);
    issue(3'b100, 32'd5,         32'd0,         4'd13, 1'b1, 32'hFFFF_FFFF, 1);
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 4'd14, 1'b1, 32'h8000_0000, 1);
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 4'd15, 1'b1, 32'd0,         1);
    issue(3'b000, 32'd0,         32'h123,       4'd1,  1'b1, 32'd0,         1);
    drain();

    // Backpressure: hold result_ready low for five valid cycles.
    @(posedge clk); #1 result_ready = 1'b0;
    issue(3'b000, 32'd3, 32'd4, 4'd6, 1'b1, 32'd12, 34);
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (result_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("bp_valid_seen", {63'd0, seen}, 64'd1);
    repeat (4) @(negedge clk);
    chk("bp_still_valid", {63'd0, result_valid}, 64'd1);
    @(posedge clk); #1 result_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_issue_ready", {63'd0, issue_ready}, 64'd1);
    chk("bp_idle_result_valid", {63'd0, result_valid}, 64'd0);

    // Flush mid-divide at T+10: no result, ready again at T+11.
    issue(3'b101, 32'd100, 32'd7, 4'd9, 1'b0, 32'd0, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_gates_ready", {63'd0, issue_ready}, 64'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_next_ready", {63'd0, issue_ready}, 64'd1);

    // Op offered while flush is high in IDLE must be dropped.
    @(posedge clk); #1;
    flush = 1'b1; issue_valid = 1'b1; funct3 = 3'b000; src1 = 32'd9; src2 = 32'd9;
    rob_in = 4'd2;
    @(negedge clk);
    chk("flush_offer_ready", {63'd0, issue_ready}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; issue_valid = 1'b0;
    repeat (40) @(negedge clk);

    issue(3'b000, 32'd3, 32'd4, 4'd12, 1'b1, 32'd12, 34);
    drain();

    // Asynchronous reset mid-CALC clears outputs at once and discards the op.
    issue(3'b100, 32'd1000, 32'd3, 4'd5, 1'b0, 32'd0, 0);
    repeat (5) @(posedge clk);
    #3 rst_aH = 1'b1;
    #1;
    chk("async_rst_result_valid", {63'd0, result_valid}, 64'd0);
    chk("async_rst_dst", {32'd0, dst}, 64'd0);
    chk("async_rst_rob", {60'd0, rob_out}, 64'd0);
    @(posedge clk); #1 rst_aH = 1'b0;
    @(negedge clk);
    chk("post_rst_issue_ready", {63'd0, issue_ready}, 64'd1);
    repeat (40) @(negedge clk);

    issue(3'b111, 32'hFFFF_FFFF, 32'h10, 4'd7, 1'b1, 32'hF, 34);
    drain();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/int_muldiv_unit.md
Name: int_muldiv_unit

Overview:
Parametrised iterative RV32M/RV64M execute unit. Sits beside the single-cycle integer ALU and takes multiply/divide ops from the integer issue queue. Runs a radix-2 shift-add multiplier and a restoring divider on operand magnitudes, with sign fix-up at the end. Has valid/ready handshakes on both sides, backpressure on the writeback port, and flush support.

Parameters:
XLEN, 32, operand/result width (32 or 64)
ROB_ID_WIDTH, 4, width of ROB tag carried with the op
EARLY_OUT, 1, if 1, a multiply with a zero operand completes in the fast path

Ports:
clk  in  1  clock
rst_aH  in  1  asynchronous reset, active-high
issue_valid  in  1  op offered by issue
issue_ready  out  1  unit can accept an op
funct3  in  3  RISC-V M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src1  in  XLEN  rs1 value
src2  in  XLEN  rs2 value
instr_rob_id_in  in  ROB_ID_WIDTH  ROB tag of the issuing op
flush  in  1  kill any in-flight or offered op
result_valid  out  1  result available
result_ready  in  1  writeback accepts result
instr_rob_id_out  out  ROB_ID_WIDTH  tag of the result
dst  out  XLEN  result data

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (async, rst_aH=1):
  - State goes to IDLE.
  - result_valid=0, dst=0, instr_rob_id_out=0.
  - issue_ready=1 once reset deasserts.
  - Reset mid-operation discards the op.
- issue_ready = (state==IDLE) & ~flush.
- Accept happens at cycle T when issue_valid & issue_ready. At accept, latch funct3, rob id, operand sign flags and operand magnitudes:
  - src1 is treated as signed for MUL, MULH, MULHSU, DIV, REM.
  - src2 is treated as signed for MUL, MULH, DIV, REM.
- Fast path (IDLE→DONE, result_valid at T+1) applies to:
  - divide by zero: quotient = all ones; remainder = src1.
  - signed overflow (src1 = 1<<(XLEN-1), src2 = all ones, DIV/REM): quotient = src1; remainder = 0.
  - EARLY_OUT=1 and a multiply with src1==0 or src2==0: result 0.
- Normal path: IDLE→CALC.
  - CALC runs exactly XLEN iterations (cycles T+1..T+XLEN), with a counter of width $clog2(XLEN)+1.
  - Multiply: 2·XLEN accumulator, one multiplier bit per cycle.
  - Divide: one quotient bit per cycle into an XLEN+1-bit partial remainder.
- FIX (cycle T+XLEN+1):
  - Negate the product if exactly one operand was treated as signed and negative.
  - Negate the quotient if the dividend and divisor signs differ.
  - Negate the remainder if the dividend was negative.
  - Select the result: low half (MUL), high half (MULH/MULHSU/MULHU), quotient, or remainder.
- DONE:
  - Normal path: result_valid=1 from T+XLEN+2.
  - dst and instr_rob_id_out are held stable while result_ready=0.
  - result_valid & result_ready → IDLE on the next edge. A new op can be accepted the following cycle; there is no same-cycle accept-on-complete.
- Flush:
  - Any state goes to IDLE on the next edge.
  - result_valid is combinationally gated by ~flush, so no result handshake can occur in a flush cycle.
  - An op offered in the flush cycle is not accepted.
- funct3 values outside the M encodings do not exist; all 8 values are defined.
- All arithmetic is modulo 2^XLEN. There is no exception output.

Test Plan:
- MUL src1=7, src2=0xFFFFFFFD, accept at T → result_valid at T+34, dst=0xFFFFFFEB, rob id echoed.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2; each at T+34.
- Fast path:
  - DIVU 5/0 → 0xFFFFFFFF at T+1.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0.
  - MUL 0×123 → 0 at T+1 with EARLY_OUT=1; at T+34 with EARLY_OUT=0.
- Backpressure: result_ready=0 for 5 cycles after result_valid → dst and rob id stable, issue_ready=0. The handshake then returns the unit to IDLE, and issue_ready=1 in the next cycle.
- Flush at T+10 of a DIV → result_valid never asserted, issue_ready=1 at T+11. A following MUL 3×4 → 12. Async rst_aH pulse mid-CALC → outputs reset immediately, no stale result.
